// File: rtl/id_ex_if.sv
// id_ex_if: ID-side operands/control, EX/MEM forwarding inputs and registered EX outputs of the ID/EX stage.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [31:0]       id_instr;
    logic              id_zero_ext;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_uses_rt;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              exmem_reg_write;
    logic [4:0]        exmem_rd;
    logic [DATA_W-1:0] exmem_data;
    logic              ex_ready;
    logic              flush;
    logic              stall_id;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_pc, id_instr, id_zero_ext, id_rs, id_rt, id_rd, id_uses_rt,
               id_reg_write, id_mem_read, id_ctrl, rf_rdata1, rf_rdata2,
               exmem_reg_write, exmem_rd, exmem_data, ex_ready, flush,
        input  stall_id, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_reg_write, ex_mem_read, ex_ctrl
    );

    modport slave (
        input  id_valid, id_pc, id_instr, id_zero_ext, id_rs, id_rt, id_rd, id_uses_rt,
               id_reg_write, id_mem_read, id_ctrl, rf_rdata1, rf_rdata2,
               exmem_reg_write, exmem_rd, exmem_data, ex_ready, flush,
        output stall_id, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_reg_write, ex_mem_read, ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM forwarding, load-use bubbles, stall and flush.
// Optional HAZARD_STATS_EN adds saturating load-use bubble and flush counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_if.slave      bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stat_lu_bubbles,
    output logic [15:0] stat_flushes
`endif
);
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic [DATA_W-1:0] imm;
    logic              lu;

    // EX/MEM result wins over the RF's own WB bypass; r0 is never forwarded
    assign fwd1_hit = bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == bus.id_rs;
    assign fwd2_hit = bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == bus.id_rt;
    assign fwd1     = fwd1_hit ? bus.exmem_data : bus.rf_rdata1;
    assign fwd2     = fwd2_hit ? bus.exmem_data : bus.rf_rdata2;
    assign imm      = {{(DATA_W-16){bus.id_instr[15] & ~bus.id_zero_ext}}, bus.id_instr[15:0]};

    assign lu = bus.id_valid && bus.ex_valid && bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                (bus.ex_rd == bus.id_rs || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));

    assign bus.stall_id = !bus.flush && (lu || !bus.ex_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_rs_data   <= '0;
            bus.ex_rt_data   <= '0;
            bus.ex_imm       <= '0;
            bus.ex_rs        <= '0;
            bus.ex_rt        <= '0;
            bus.ex_rd        <= '0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_ctrl      <= '0;
        end else if (bus.flush) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
        end else if (bus.ex_ready) begin
            if (lu) begin
                bus.ex_valid     <= 1'b0;
                bus.ex_reg_write <= 1'b0;
                bus.ex_mem_read  <= 1'b0;
                bus.ex_ctrl      <= '0;
            end else begin
                bus.ex_valid     <= bus.id_valid;
                bus.ex_pc        <= bus.id_pc;
                bus.ex_rs_data   <= fwd1;
                bus.ex_rt_data   <= fwd2;
                bus.ex_imm       <= imm;
                bus.ex_rs        <= bus.id_rs;
                bus.ex_rt        <= bus.id_rt;
                bus.ex_rd        <= bus.id_rd;
                bus.ex_reg_write <= bus.id_reg_write && bus.id_valid;
                bus.ex_mem_read  <= bus.id_mem_read && bus.id_valid;
                bus.ex_ctrl      <= bus.id_ctrl;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_lu_bubbles <= '0;
            stat_flushes    <= '0;
        end else begin
            if (!bus.flush && bus.ex_ready && lu && stat_lu_bubbles != 16'hFFFF)
                stat_lu_bubbles <= stat_lu_bubbles + 16'd1;
            if (bus.flush && stat_flushes != 16'hFFFF)
                stat_flushes <= stat_flushes + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of forwarding, load-use bubbles, immediates, stall/flush and reset.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;

    id_ex_if #(.DATA_W(32), .CTRL_W(12)) bus ();

`ifdef HAZARD_STATS_EN
    logic [15:0] stat_lu_bubbles;
    logic [15:0] stat_flushes;
    id_ex_stage #(.DATA_W(32), .CTRL_W(12)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .stat_lu_bubbles(stat_lu_bubbles), .stat_flushes(stat_flushes)
    );
`else
    id_ex_stage #(.DATA_W(32), .CTRL_W(12)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_instr = 0; bus.id_zero_ext = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_uses_rt = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_ctrl = 0;
        bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_data = 0;
        bus.ex_ready = 1; bus.flush = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        bus.id_valid = 1; bus.flush = 1; bus.id_pc = 32'h44; bus.id_rd = 5'd3;
        bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_ctrl = 12'hABC; bus.rf_rdata1 = 32'h77;
        bus.id_instr = 32'h0000_FFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read} !== 3'b000)
                $display("FAIL reset_ctrl cyc%0d got %b exp 000", i, {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read});
            else passes++;
            checks++;
            if ({bus.ex_pc, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_ctrl} !== '0)
                $display("FAIL reset_data cyc%0d pc=%h rs_data=%h imm=%h ctrl=%h exp all 0", i, bus.ex_pc, bus.ex_rs_data, bus.ex_imm, bus.ex_ctrl);
            else passes++;
        end
        checks++;
        if (bus.stall_id !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.stall_id);
        else passes++;
        reset = 0; bus.flush = 0;
        step();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h44 || bus.ex_rs_data !== 32'h77 || bus.ex_ctrl !== 12'hABC)
            $display("FAIL first_capture valid=%b pc=%h rs_data=%h ctrl=%h exp 1/44/77/abc", bus.ex_valid, bus.ex_pc, bus.ex_rs_data, bus.ex_ctrl);
        else passes++;
        checks++;
        if (bus.ex_imm !== 32'hFFFF_FFFF || bus.ex_rd !== 5'd3 || bus.ex_reg_write !== 1'b1 || bus.ex_mem_read !== 1'b1)
            $display("FAIL first_capture_ctrl imm=%h rd=%0d rw=%b mr=%b exp ffffffff/3/1/1", bus.ex_imm, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read);
        else passes++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rd = 5'd8; bus.id_rs = 5'd1;
        step();
        bus.id_mem_read = 0; bus.id_rs = 5'd8; bus.id_rt = 5'd9; bus.id_uses_rt = 1; bus.id_rd = 5'd10;
        bus.rf_rdata1 = 32'h5555; bus.rf_rdata2 = 32'h77;
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) $display("FAIL lu_stall got %b exp 1", bus.stall_id);
        else passes++;
        step();
        checks++;
        if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read} !== 3'b000)
            $display("FAIL lu_bubble got %b exp 000", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read});
        else passes++;
        checks++;
        if (bus.stall_id !== 1'b0) $display("FAIL lu_stall_once got %b exp 0", bus.stall_id);
        else passes++;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd8; bus.exmem_data = 32'h1234;
        step();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs_data !== 32'h1234 || bus.ex_rt_data !== 32'h77 || bus.ex_rd !== 5'd10 || bus.ex_reg_write !== 1'b1)
            $display("FAIL lu_forward valid=%b rs_data=%h rt_data=%h rd=%0d rw=%b exp 1/1234/77/10/1",
                     bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data, bus.ex_rd, bus.ex_reg_write);
        else passes++;
    endtask

    task automatic test_r0_forward();
        clear_inputs();
        bus.id_valid = 1; bus.exmem_reg_write = 1; bus.exmem_rd = 5'd0; bus.exmem_data = 32'hDEAD;
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.rf_rdata1 = 32'h0; bus.rf_rdata2 = 32'h0;
        step();
        checks++;
        if (bus.ex_rs_data !== 32'h0 || bus.ex_rt_data !== 32'h0)
            $display("FAIL r0_no_fwd rs_data=%h rt_data=%h exp 0/0", bus.ex_rs_data, bus.ex_rt_data);
        else passes++;
        bus.exmem_rd = 5'd7; bus.id_rt = 5'd7; bus.rf_rdata2 = 32'h11; bus.rf_rdata1 = 32'h22;
        step();
        checks++;
        if (bus.ex_rt_data !== 32'hDEAD || bus.ex_rs_data !== 32'h22)
            $display("FAIL fwd2 rt_data=%h rs_data=%h exp dead/22", bus.ex_rt_data, bus.ex_rs_data);
        else passes++;
        bus.exmem_reg_write = 0;
        step();
        checks++;
        if (bus.ex_rt_data !== 32'h11) $display("FAIL fwd2_no_write rt_data=%h exp 11", bus.ex_rt_data);
        else passes++;
    endtask

    task automatic test_imm();
        clear_inputs();
        bus.id_valid = 1; bus.id_instr = 32'h1234_8001; bus.id_zero_ext = 0;
        step();
        checks++;
        if (bus.ex_imm !== 32'hFFFF_8001) $display("FAIL imm_sext got %h exp ffff8001", bus.ex_imm);
        else passes++;
        bus.id_zero_ext = 1;
        step();
        checks++;
        if (bus.ex_imm !== 32'h0000_8001) $display("FAIL imm_zext got %h exp 00008001", bus.ex_imm);
        else passes++;
        bus.id_zero_ext = 0; bus.id_instr = 32'h0000_7FFF;
        step();
        checks++;
        if (bus.ex_imm !== 32'h0000_7FFF) $display("FAIL imm_pos got %h exp 00007fff", bus.ex_imm);
        else passes++;
    endtask

    task automatic test_invalid();
        clear_inputs();
        bus.id_valid = 0; bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_rd = 5'd4;
        step();
        checks++;
        if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read} !== 3'b000)
            $display("FAIL invalid_bubble got %b exp 000", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read});
        else passes++;
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        bus.id_valid = 1; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rd = 5'd5; bus.id_rs = 5'd1;
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) $display("FAIL b2b_no_stall got %b exp 0", bus.stall_id);
        else passes++;
        step();
        bus.id_rs = 5'd5; bus.id_rd = 5'd6;
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) $display("FAIL b2b_stall1 got %b exp 1", bus.stall_id);
        else passes++;
        step();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.stall_id !== 1'b0)
            $display("FAIL b2b_bubble1 valid=%b stall=%b exp 0/0", bus.ex_valid, bus.stall_id);
        else passes++;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd5; bus.exmem_data = 32'h40;
        step();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.ex_rs_data !== 32'h40 || bus.ex_rd !== 5'd6)
            $display("FAIL b2b_load2 valid=%b mr=%b rs_data=%h rd=%0d exp 1/1/40/6", bus.ex_valid, bus.ex_mem_read, bus.ex_rs_data, bus.ex_rd);
        else passes++;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_data = 0;
        bus.id_mem_read = 0; bus.id_rs = 5'd2; bus.id_rt = 5'd6; bus.id_uses_rt = 1; bus.id_rd = 5'd7;
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) $display("FAIL b2b_stall_rt got %b exp 1", bus.stall_id);
        else passes++;
        step();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd6; bus.exmem_data = 32'h99;
        step();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rt_data !== 32'h99 || bus.ex_mem_read !== 1'b0)
            $display("FAIL b2b_rt_fwd valid=%b rt_data=%h mr=%b exp 1/99/0", bus.ex_valid, bus.ex_rt_data, bus.ex_mem_read);
        else passes++;
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        bus.id_valid = 1; bus.id_pc = 32'h200; bus.id_rd = 5'd3; bus.id_reg_write = 1;
        step();
        bus.ex_ready = 0; bus.id_pc = 32'h300; bus.id_rd = 5'd12;
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) $display("FAIL hold_stall1 got %b exp 1", bus.stall_id);
        else passes++;
        step();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h200 || bus.ex_rd !== 5'd3 || bus.ex_reg_write !== 1'b1)
            $display("FAIL hold_frozen valid=%b pc=%h rd=%0d rw=%b exp 1/200/3/1", bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_reg_write);
        else passes++;
        bus.flush = 1;
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) $display("FAIL flush_stall got %b exp 0", bus.stall_id);
        else passes++;
        step();
        checks++;
        if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read} !== 3'b000)
            $display("FAIL flush_kill got %b exp 000", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read});
        else passes++;
        bus.flush = 0;
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) $display("FAIL hold_stall3 got %b exp 1", bus.stall_id);
        else passes++;
        step();
        checks++;
        if (bus.ex_valid !== 1'b0) $display("FAIL hold_after_flush got %b exp 0", bus.ex_valid);
        else passes++;
        bus.ex_ready = 1;
        step();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h300 || bus.ex_rd !== 5'd12)
            $display("FAIL resume valid=%b pc=%h rd=%0d exp 1/300/12", bus.ex_valid, bus.ex_pc, bus.ex_rd);
        else passes++;
        bus.flush = 1;
        step();
        bus.flush = 0;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0)
            $display("FAIL flush2 valid=%b rw=%b exp 0/0", bus.ex_valid, bus.ex_reg_write);
        else passes++;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        checks++;
        if (stat_lu_bubbles !== 16'd3) $display("FAIL stat_lu got %0d exp 3", stat_lu_bubbles);
        else passes++;
        checks++;
        if (stat_flushes !== 16'd2) $display("FAIL stat_flush got %0d exp 2", stat_flushes);
        else passes++;
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (stat_lu_bubbles !== 16'd0 || stat_flushes !== 16'd0)
            $display("FAIL stat_reset lu=%0d fl=%0d exp 0/0", stat_lu_bubbles, stat_flushes);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_r0_forward();
        test_imm();
        test_invalid();
        test_back_to_back();
        test_stall_flush();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the MIPS pipeline, directly downstream of the register file.
- Consumes the register file's two read ports plus decoded control and forwards EX/MEM results into the operands.
- Detects load-use hazards and inserts bubbles.
- Holds the ID/EX pipeline register with stall and flush handling.

Parameters:
DATA_W, 32, operand/PC/immediate width
CTRL_W, 12, width of opaque EX/MEM/WB control bundle passed through

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID slot holds a real instruction
id_pc  in  DATA_W  PC of ID instruction
id_instr  in  32  raw instruction (imm = bits 15:0)
id_zero_ext  in  1  1 = zero-extend imm, 0 = sign-extend
id_rs  in  5  source register 1 index (matches RF Read_register1)
id_rt  in  5  source register 2 index (matches RF Read_register2)
id_rd  in  5  destination index (already muxed rt/rd/31)
id_uses_rt  in  1  instruction reads rt as a source
id_reg_write  in  1  instruction writes id_rd
id_mem_read  in  1  instruction is a load
id_ctrl  in  CTRL_W  other control, passed through
rf_rdata1  in  DATA_W  RF Read_data1 (already WB-bypassed)
rf_rdata2  in  DATA_W  RF Read_data2
exmem_reg_write  in  1  EX/MEM stage will write
exmem_rd  in  5  EX/MEM destination
exmem_data  in  DATA_W  EX/MEM ALU result
ex_ready  in  1  EX can accept a new entry this cycle
flush  in  1  kill ID and EX contents (taken branch/jump)
stall_id  out  1  hold IF/ID this cycle
ex_valid  out  1  EX register holds a real instruction
ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered operands
ex_rs, ex_rt, ex_rd  out  5 each  registered indices (for EX-stage forwarding)
ex_reg_write, ex_mem_read  out  1 each  registered control; forced 0 when ex_valid = 0
ex_ctrl  out  CTRL_W  registered pass-through

Behaviour:
- Reset:
  - All registered outputs 0 on the first clk edge with reset = 1.
  - Reset overrides flush and all other inputs.
  - stall_id is combinational, but ex_valid = 0 after reset, so stall_id = 0 then.
- Forwarding (combinational, ID side):
  - fwd1 = exmem_data if exmem_reg_write && exmem_rd != 0 && exmem_rd == id_rs, else rf_rdata1.
  - fwd2 is the same against id_rt and rf_rdata2.
  - EX/MEM beats the RF's WB bypass. Register 0 is never forwarded.
- Load-use hazard:
  - lu = id_valid && ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt)).
- stall_id = !flush && (lu || !ex_ready).
- Register update, evaluated in priority order each posedge:
  1. reset: clear.
  2. flush: ex_valid <= 0, ex_reg_write/ex_mem_read <= 0. Applies even if ex_ready = 0.
  3. !ex_ready: hold every EX register unchanged.
  4. lu: bubble. ex_valid <= 0, control <= 0, data fields don't-care (implementation holds them). ID is held, so the instruction re-evaluates next cycle; by then the load has moved to EX/MEM and is forwarded.
  5. Otherwise capture:
     - ex_valid <= id_valid
     - ex_rs_data <= fwd1, ex_rt_data <= fwd2
     - ex_imm <= zero/sign-extended instr[15:0]
     - indices, pc, ctrl captured
     - ex_reg_write <= id_reg_write && id_valid, ex_mem_read <= id_mem_read && id_valid
- Latency: 1 cycle ID->EX. At most one bubble per load-use pair.
- id_valid = 0 never triggers lu and produces a bubble on capture.
- Back-to-back loads each incur their own check; a load followed by a dependent load stalls once.
- Reset mid-stall: stall state is purely combinational from registered ex_*, so it clears within one cycle.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs stat_lu_bubbles[15:0] and stat_flushes[15:0].
  - stat_lu_bubbles increments on each cycle branch 4 (lu) is taken; stat_flushes increments on each cycle flush is asserted.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset with id_valid = 1 and flush = 1 for 2 cycles -> all ex_* = 0, stall_id = 0; first normal capture follows reset deassert.
- EX holds lw rd = 8 (ex_mem_read = 1); ID add rs = 8 -> stall_id = 1 one cycle, ex_valid = 0 bubble. Next cycle, exmem_rd = 8, exmem_data = 32'h1234 -> ex_rs_data = 32'h1234, ex_valid = 1.
- exmem_rd = 0, exmem_reg_write = 1, exmem_data = 32'hDEAD, id_rs = 0, rf_rdata1 = 0 -> ex_rs_data = 0.
- id_instr[15:0] = 16'h8001, id_zero_ext = 0 -> ex_imm = 32'hFFFF8001; id_zero_ext = 1 -> 32'h00008001.
- ex_ready = 0 for 3 cycles -> EX outputs frozen, stall_id = 1; flush in cycle 2 -> ex_valid = 0 next edge, stall_id = 0 that cycle.
- HAZARD_STATS_EN: 3 load-use bubbles plus 2 flushes -> stat_lu_bubbles = 3, stat_flushes = 2.
